// File: rtl/mips_pkg.sv
// Shared types and constants for the mult/div unit of the pipelined MIPS core.
// Holds the opcode and FSM state enums, the iteration count and small op-decode helpers.
// Imported by the interface, the unit and the testbench.
package mips_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } md_state_e;

    localparam int MD_ITER = 32;

    // Ops that occupy the iterative datapath (as opposed to MTHI/MTLO moves).
    function automatic logic is_arith_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage and the mult/div unit.
// master: start/op/flush/rs_data/rt_data out, busy/done/hi/lo in; slave is the mirror.
// No handshake beyond busy: the stall logic holds the instruction while busy is high.
interface mult_div_unit_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              start;
    md_op_e            op;
    logic              flush;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, flush, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, flush, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Latency: mult/div 33 cycles from accept to HI/LO update; MTHI/MTLO one cycle.
// Backpressure: busy high while not IDLE; start ignored except in IDLE and in the final SIGN cycle.
// Ports: clk, rst_n (async active-low), md (slave modport: start/op/flush/rs_data/rt_data in,
//        busy/done/hi/lo out).
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_div_unit_if.slave   md
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e           state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]   opnd;      // mult: multiplicand magnitude; div: divisor magnitude
    logic                op_div;
    logic                neg_res;   // product / quotient sign
    logic                neg_rem;   // remainder follows dividend sign
    logic                div_zero;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q, lo_q;

    logic accept;      // load a new mult/div this edge
    logic write_res;   // commit result to HI/LO this edge
    logic mt_hi, mt_lo;
    logic start_arith, start_mt_ok;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        write_res   = 1'b0;
        start_arith = md.start && is_arith_op(md.op);
        // A move is taken in IDLE, or in SIGN alongside the result write so that
        // the later instruction in program order wins.
        start_mt_ok = 1'b0;
        case (state)
            IDLE: begin
                start_mt_ok = 1'b1;
                if (start_arith) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (md.flush)           state_nxt = IDLE;
                else if (cnt == '0)     state_nxt = SIGN;
            end
            SIGN: begin
                if (md.flush) begin
                    state_nxt = IDLE;
                end else begin
                    write_res   = 1'b1;
                    start_mt_ok = 1'b1;
                    if (start_arith) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        mt_hi = start_mt_ok && md.start && (md.op == MD_MTHI);
        mt_lo = start_mt_ok && md.start && (md.op == MD_MTLO);
    end

    // ---------------- operand conditioning ----------------
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = is_signed_op(md.op) && md.rs_data[DATA_W-1];
        b_neg = is_signed_op(md.op) && md.rt_data[DATA_W-1];
        a_mag = a_neg ? (~md.rs_data + 1'b1) : md.rs_data;
        b_mag = b_neg ? (~md.rt_data + 1'b1) : md.rt_data;
    end

    // ---------------- iteration step ----------------
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W+1:0]   div_diff;
    logic [DATA_W-1:0]   div_rem;
    logic [2*DATA_W-1:0] div_next;

    always_comb begin
        // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[DATA_W-1:1]};

        // Restoring step: bring in the next dividend bit, trial-subtract the divisor,
        // keep the difference only when it did not borrow.
        div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        div_rem   = div_diff[DATA_W+1] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
        div_next  = {div_rem, acc[DATA_W-2:0], ~div_diff[DATA_W+1]};
    end

    // ---------------- sign fix-up / result select ----------------
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    always_comb begin
        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        quo_fix  = neg_res ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0];
        // With a zero divisor the remainder ends up as |dividend|; restoring the
        // dividend's sign gives back rs_data exactly.
        rem_fix  = neg_rem ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
        if (op_div) begin
            res_hi = rem_fix;
            res_lo = div_zero ? '1 : quo_fix;
        end else begin
            res_hi = prod_fix[2*DATA_W-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end

    // ---------------- datapath and HI/LO ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= write_res;
            if (accept) begin
                cnt      <= CNT_W'(DATA_W - 1);
                op_div   <= is_div_op(md.op);
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (md.rt_data == '0);
                if (is_div_op(md.op)) begin
                    acc  <= {{DATA_W{1'b0}}, a_mag};
                    opnd <= b_mag;
                end else begin
                    acc  <= {{DATA_W{1'b0}}, b_mag};
                    opnd <= a_mag;
                end
            end else if (state == RUN && !md.flush) begin
                acc <= op_div ? div_next : mul_next;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end

            if (write_res) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            if (mt_hi) hi_q <= md.rs_data;
            if (mt_lo) lo_q <= md.rs_data;
        end
    end

    assign md.busy = (state != IDLE);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule
